data_mem_responder: RTL and testbench

Memory-side responder for the execution core's RAM read/write interface (rd_en/rd_addr/rd_data, wr_en/wr_addr/wr_data). It holds a byte-organised data RAM of 2^ADDR_BITS bytes, accessed as 32-bit little-endian words. Reads are pipelined with a fixed latency and a valid strobe. Writes are byte-masked and complete in one cycle. Misaligned and out-of-range accesses are rejected and flagged. It sits below rv32i_top as the RAM the core talks to.

---
 rtl/data_mem_responder_if.sv | 24 ++
 rtl/data_mem_responder.sv | 86 ++++++++
 tb/tb_data_mem_responder.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Core-to-RAM bus: pipelined word reads with valid strobe, byte-masked writes.
// The core drives through master; the RAM responder connects through slave.
interface data_mem_responder_if;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_err;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_err;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_strb,
        input  rd_data, rd_valid, rd_err, wr_err
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_strb,
        output rd_data, rd_valid, rd_err, wr_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Byte-organised data RAM of 2^ADDR_BITS bytes seen as little-endian 32-bit words.
// Reads return after READ_LATENCY cycles; bad addresses are answered with an error.
module data_mem_responder #(
    parameter int unsigned ADDR_BITS    = 16,
    parameter int unsigned READ_LATENCY = 1
) (
    input logic                 clk,
    input logic                 reset_n,
    data_mem_responder_if.slave bus
);

    localparam int unsigned WA    = ADDR_BITS - 2;
    localparam int unsigned WORDS = 2 ** WA;

    logic [3:0][7:0] mem_q [WORDS];

    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [READ_LATENCY-1:0] err_q, err_d;
    logic [31:0]             data_q [READ_LATENCY];
    logic [31:0]             data_d [READ_LATENCY];
    logic                    wr_err_q, wr_err_d;

    logic          rd_bad, wr_bad;
    logic [WA-1:0] rd_idx, wr_idx;

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> ADDR_BITS) != 32'd0);
    endfunction

    always_comb begin
        rd_bad = addr_bad(bus.rd_addr);
        wr_bad = addr_bad(bus.wr_addr);
        rd_idx = bus.rd_addr[ADDR_BITS-1:2];
        wr_idx = bus.wr_addr[ADDR_BITS-1:2];
    end

    // Writes are gated by reset_n so a write sampled during reset leaves the RAM intact.
    always_ff @(posedge clk) begin
        if (reset_n && bus.wr_en && !wr_bad) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (bus.wr_strb[i]) begin
                    mem_q[wr_idx][i] <= bus.wr_data[8*i +: 8];
                end
            end
        end
    end

    // Stage 0 captures the pre-write word, so a same-cycle read sees the old contents.
    always_comb begin
        vld_d[0]  = bus.rd_en;
        err_d[0]  = bus.rd_en && rd_bad;
        data_d[0] = (bus.rd_en && !rd_bad) ? mem_q[rd_idx] : '0;
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            vld_d[i]  = vld_q[i-1];
            err_d[i]  = err_q[i-1];
            data_d[i] = data_q[i-1];
        end
        wr_err_d = bus.wr_en && wr_bad;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_q    <= '0;
            err_q    <= '0;
            wr_err_q <= 1'b0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q    <= vld_d;
            err_q    <= err_d;
            wr_err_q <= wr_err_d;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    always_comb begin
        bus.rd_valid = vld_q[READ_LATENCY-1];
        bus.rd_err   = err_q[READ_LATENCY-1];
        bus.rd_data  = data_q[READ_LATENCY-1];
        bus.wr_err   = wr_err_q;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at READ_LATENCY 1 and 3 side by side,
// with a byte-level memory model feeding per-instance response scoreboards.
module tb_data_mem_responder;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int unsigned due;
    } rsp_t;

    logic clk;
    logic reset_n;
    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic mon_on = 1'b0;
    logic wexp = 1'b0;

    rsp_t q1[$];
    rsp_t q3[$];
    logic [7:0] model [int unsigned];

    data_mem_responder_if if1 ();
    data_mem_responder_if if3 ();

    data_mem_responder #(.ADDR_BITS(16), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .bus(if1)
    );
    data_mem_responder #(.ADDR_BITS(16), .READ_LATENCY(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .bus(if3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:16] != 16'h0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        wexp <= reset_n && if1.wr_en && bad(if1.wr_addr);
        if (!reset_n) begin
            q1.delete();
            q3.delete();
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            rsp_t r;
            if (q1.size() > 0 && q1[0].due < cyc) begin
                chk("lat1_late", cyc, q1[0].due);
                void'(q1.pop_front());
            end
            if (q1.size() > 0 && q1[0].due == cyc) begin
                r = q1.pop_front();
                chk("lat1_valid", 32'(if1.rd_valid), 32'd1);
                chk("lat1_data", if1.rd_data, r.data);
                chk("lat1_err", 32'(if1.rd_err), 32'(r.err));
            end else begin
                chk("lat1_idle_valid", 32'(if1.rd_valid), 32'd0);
                chk("lat1_idle_data", if1.rd_data, 32'd0);
                chk("lat1_idle_err", 32'(if1.rd_err), 32'd0);
            end
            chk("lat1_wr_err", 32'(if1.wr_err), 32'(wexp));

            if (q3.size() > 0 && q3[0].due < cyc) begin
                chk("lat3_late", cyc, q3[0].due);
                void'(q3.pop_front());
            end
            if (q3.size() > 0 && q3[0].due == cyc) begin
                r = q3.pop_front();
                chk("lat3_valid", 32'(if3.rd_valid), 32'd1);
                chk("lat3_data", if3.rd_data, r.data);
                chk("lat3_err", 32'(if3.rd_err), 32'(r.err));
            end else begin
                chk("lat3_idle_valid", 32'(if3.rd_valid), 32'd0);
                chk("lat3_idle_data", if3.rd_data, 32'd0);
                chk("lat3_idle_err", 32'(if3.rd_err), 32'd0);
            end
            chk("lat3_wr_err", 32'(if3.wr_err), 32'(wexp));
        end
    end

    // One clock of stimulus: drive both DUTs, push expected reads, update the model.
    task automatic step(input logic re, input logic [31:0] ra,
                        input logic we, input logic [31:0] wa,
                        input logic [31:0] wd, input logic [3:0] ws);
        rsp_t r;
        if1.rd_en = re;  if1.rd_addr = ra;
        if1.wr_en = we;  if1.wr_addr = wa;  if1.wr_data = wd;  if1.wr_strb = ws;
        if3.rd_en = re;  if3.rd_addr = ra;
        if3.wr_en = we;  if3.wr_addr = wa;  if3.wr_data = wd;  if3.wr_strb = ws;
        if (re && reset_n) begin
            r.err = bad(ra);
            r.data = '0;
            if (!r.err) begin
                for (int b = 0; b < 4; b++) begin
                    r.data[8*b +: 8] = model.exists(ra + b) ? model[ra + b] : 8'hxx;
                end
            end
            r.due = cyc + 1;
            q1.push_back(r);
            r.due = cyc + 3;
            q3.push_back(r);
        end
        if (we && reset_n && !bad(wa)) begin
            for (int b = 0; b < 4; b++) begin
                if (ws[b]) model[wa + b] = wd[8*b +: 8];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        step(1'b0, 32'h0, 1'b1, a, d, s);
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b1, a, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        idle(1);
        mon_on = 1'b1;
        idle(2);
        reset_n = 1'b1;

        // write then read back
        wr(32'h10, 32'hDEADBEEF, 4'b1111);
        rd(32'h10);
        idle(4);

        // byte mask, including an all-zero strobe no-op
        wr(32'h20, 32'h11223344, 4'b1111);
        wr(32'h20, 32'hAABBCCDD, 4'b0101);
        wr(32'h20, 32'h55555555, 4'b0000);
        rd(32'h20);
        idle(4);

        // bad addresses
        wr(32'h0, 32'hCAFEF00D, 4'b1111);
        rd(32'h12);
        wr(32'h00010000, 32'hFFFFFFFF, 4'b1111);
        wr(32'h00000002, 32'h12345678, 4'b1111);
        rd(32'h00010000);
        rd(32'h80000000);
        rd(32'h0);
        idle(4);

        // highest legal word
        wr(32'hFFFC, 32'h0BADF00D, 4'b1111);
        rd(32'hFFFC);
        idle(4);

        // read during write to the same word, then different words
        wr(32'h30, 32'h1, 4'b1111);
        step(1'b1, 32'h30, 1'b1, 32'h30, 32'h2, 4'b1111);
        rd(32'h30);
        step(1'b1, 32'h10, 1'b1, 32'h34, 32'h77, 4'b1111);
        rd(32'h34);
        idle(4);

        // streaming reads
        for (int i = 0; i < 8; i++) wr(32'(4 * i), 32'(i), 4'b1111);
        for (int i = 0; i < 8; i++) rd(32'(4 * i));
        idle(5);

        // reset with LAT3 reads in flight
        rd(32'h4);
        rd(32'h8);
        reset_n = 1'b0;
        step(1'b0, 32'h0, 1'b1, 32'h4, 32'hEEEEEEEE, 4'b1111);
        reset_n = 1'b1;
        idle(6);
        rd(32'h4);
        rd(32'h8);
        idle(2);

        for (int i = 0; i < 20 && (q1.size() > 0 || q3.size() > 0); i++) idle(1);
        chk("lat1_drained", q1.size(), 32'd0);
        chk("lat3_drained", q3.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
